// File: rtl/store_pkg.sv
// Shared types and helpers for the truncating store path: access sizes,
// controller states and the byte-count lookup.
package store_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } access_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      DONE = 2'b10
   } store_state_t;

   function automatic logic [3:0] size_bytes(input access_size_t sz);
      logic [3:0] n;
      case (sz)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         SZ_D:    n = 4'd8;
         default: n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fits_signed.sv
// Reports whether a 64-bit value survives narrowing to the access size
// followed by sign extension back to 64 bits.
module fits_signed
   import store_pkg::*;
(
   input  logic [DATA_W-1:0] value,
   input  access_size_t      size,
   output logic              fits
);

   // Compare against the sign-extended low bits; a dword always fits.
   always_comb begin
      fits = 1'b1;
      case (size)
         SZ_B:    fits = (value == {{56{value[7]}},  value[7:0]});
         SZ_H:    fits = (value == {{48{value[15]}}, value[15:0]});
         SZ_W:    fits = (value == {{32{value[31]}}, value[31:0]});
         SZ_D:    fits = 1'b1;
         default: fits = 1'b1;
      endcase
   end

endmodule

// File: rtl/truncating_store_unit.sv
// Narrows a register value to STURB/H/W/D size and streams it little-endian,
// one byte per accepted beat, onto the byte-wide data-memory write port.
module truncating_store_unit
   import store_pkg::*;
#(
   parameter int ADDR_W = 64
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ready
);

   store_state_t      state_r, state_nxt_s;
   access_size_t      size_r, size_nxt_s;
   logic [2:0]        k_r, k_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [DATA_W-1:0] data_r, data_nxt_s;
   logic              flag_r, flag_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic              done_r, done_nxt_s;
   logic              ovf_r, ovf_nxt_s;
   logic              wr_en_r, wr_en_nxt_s;
   logic              fits_s;
   logic              last_s;

   fits_signed u_fits (
      .value (wdata),
      .size  (access_size_t'(size)),
      .fits  (fits_s)
   );

   assign last_s = ({1'b0, k_r} == (size_bytes(size_r) - 4'd1));

   // Next-state and next-output logic; addr_r/data_r advance per accepted
   // beat so the port always shows the current byte straight from flops.
   always_comb begin
      state_nxt_s = state_r;
      size_nxt_s  = size_r;
      k_nxt_s     = k_r;
      addr_nxt_s  = addr_r;
      data_nxt_s  = data_r;
      flag_nxt_s  = flag_r;
      busy_nxt_s  = busy_r;
      wr_en_nxt_s = wr_en_r;
      done_nxt_s  = 1'b0;
      ovf_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = SEND;
               size_nxt_s  = access_size_t'(size);
               k_nxt_s     = 3'd0;
               addr_nxt_s  = addr;
               data_nxt_s  = wdata;
               flag_nxt_s  = ~fits_s;
               busy_nxt_s  = 1'b1;
               wr_en_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SEND: begin
            if (mem_ready) begin
               if (last_s) begin
                  state_nxt_s = DONE;
                  wr_en_nxt_s = 1'b0;
                  done_nxt_s  = 1'b1;
                  ovf_nxt_s   = flag_r;
                  k_nxt_s     = 3'd0;
                  addr_nxt_s  = {ADDR_W{1'b0}};
                  data_nxt_s  = {DATA_W{1'b0}};
               end else begin
                  k_nxt_s     = k_r + 3'd1;
                  addr_nxt_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  data_nxt_s  = {8'h00, data_r[DATA_W-1:8]};
               end
            end else begin
               state_nxt_s = SEND;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
         end
         default: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
            wr_en_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         size_r  <= SZ_B;
         k_r     <= 3'd0;
         addr_r  <= {ADDR_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
         flag_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         ovf_r   <= 1'b0;
         wr_en_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         size_r  <= size_nxt_s;
         k_r     <= k_nxt_s;
         addr_r  <= addr_nxt_s;
         data_r  <= data_nxt_s;
         flag_r  <= flag_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
         ovf_r   <= ovf_nxt_s;
         wr_en_r <= wr_en_nxt_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign overflow  = ovf_r;
   assign mem_wr_en = wr_en_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = data_r[7:0];

endmodule

// File: tb/tb_truncating_store_unit.sv
// Self-checking bench for truncating_store_unit: directed table, hand-written
// back-to-back and reset sequences, and randomized transfers against a model.
module tb_truncating_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  size;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        busy, done, overflow, mem_wr_en;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ready;

   int checks = 0;
   int failures = 0;

   truncating_store_unit #(.ADDR_W(64)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sz;
      logic [63:0] a;
      logic [63:0] d;
      int          mode;     // 0: ready always, 1: toggling, 2: random
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Reference: does sign-extending the low 8*2^sz bits reproduce d?
   function automatic logic ref_ovf(input logic [1:0] sz, input logic [63:0] d);
      int w;
      logic [63:0] t;
      logic signed [63:0] s;
      if (sz == 2'd3) return 1'b0;
      w = 8 << sz;
      t = d << (64 - w);
      s = $signed(t) >>> (64 - w);
      return (s != $signed(d));
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Follows one transfer from the cycle after its start edge to done.
   task automatic monitor(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                          input int mode, input logic exp_ovf,
                          input logic [63:0] alt_a, input logic [63:0] alt_d, input bit hold_start);
      int k = 0;
      int cyc = 0;
      int nb = 1 << sz;
      bit fin = 1'b0;
      bit rdy;
      logic [63:0] ea;
      for (int t = 0; t < 300 && !fin; t++) begin
         @(negedge clk);
         cyc++;
         if (t == 0) begin
            addr  = alt_a;
            wdata = alt_d;
            if (!hold_start) begin
               start = 1'b0;
               size  = 2'($urandom_range(0, 3));
            end
         end
         if (done) begin
            chk("beat_count", 64'(k), 64'(nb));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
            chk("busy_in_done", 64'(busy), 64'd1);
            chk("wr_en_in_done", 64'(mem_wr_en), 64'd0);
            if (mode == 0) chk("done_latency", 64'(cyc), 64'(nb + 1));
            mem_ready = 1'b0;
            fin = 1'b1;
         end else if (mem_wr_en && k < nb) begin
            ea = a + 64'(k);
            chk("beat_addr", mem_addr, ea);
            chk("beat_data", 64'(mem_wdata), 64'(d[8*k +: 8]));
            chk("busy_in_send", 64'(busy), 64'd1);
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (t % 2 == 0);
               default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            mem_ready = rdy;
            if (rdy) k++;
         end else begin
            chk("unexpected_idle_or_extra", {61'd0, busy, mem_wr_en, done}, {61'd0, 3'b110});
            fin = 1'b1;
         end
      end
      if (!fin) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_txn(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                         input int mode, input logic exp_ovf);
      @(negedge clk);
      chk("idle_before_start", {62'd0, busy, mem_wr_en}, 64'd0);
      start = 1'b1;
      size  = sz;
      addr  = a;
      wdata = d;
      monitor(sz, a, d, mode, exp_ovf, rnd64(), rnd64(), 1'b0);
   endtask

   initial begin
      logic [63:0] d, t;
      logic [1:0]  sz;
      int bad;

      vecs[0] = '{2'd0, 64'h100,                 64'hFFFF_FFFF_FFFF_FF80, 0, 1'b0};
      vecs[1] = '{2'd1, 64'h200,                 64'h0000_0000_0001_8000, 0, 1'b1};
      vecs[2] = '{2'd3, 64'h1000,                64'h0123_4567_89AB_CDEF, 1, 1'b0};
      vecs[3] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_7FFF_FFFF, 0, 1'b0};
      vecs[4] = '{2'd0, 64'h40,                  64'h0000_0000_0000_007F, 0, 1'b0};
      vecs[5] = '{2'd0, 64'h41,                  64'h0000_0000_0000_0080, 0, 1'b1};
      vecs[6] = '{2'd2, 64'h80,                  64'h0000_0000_8000_0000, 1, 1'b1};
      vecs[7] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, 1'b0};

      reset_n   = 1'b0;
      start     = 1'b0;
      size      = 2'd0;
      addr      = 64'd0;
      wdata     = 64'd0;
      mem_ready = 1'b0;
      #1;
      chk("reset_ctrl", {60'd0, busy, done, overflow, mem_wr_en}, 64'd0);
      chk("reset_addr", mem_addr, 64'd0);
      chk("reset_data", 64'(mem_wdata), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].sz, vecs[i].a, vecs[i].d, vecs[i].mode, vecs[i].exp_ovf);

      // Back-to-back: start held high through a word store, inputs switched mid-transfer.
      @(negedge clk);
      start = 1'b1;
      size  = 2'd2;
      addr  = 64'h500;
      wdata = 64'h1122_3344_5566_7788;
      monitor(2'd2, 64'h500, 64'h1122_3344_5566_7788, 0, 1'b1,
              64'h600, 64'hFFFF_FFFF_A1B2_C3D4, 1'b1);
      @(negedge clk);
      chk("b2b_idle_gap", {61'd0, busy, mem_wr_en, done}, 64'd0);
      monitor(2'd2, 64'h600, 64'hFFFF_FFFF_A1B2_C3D4, 0, 1'b0, rnd64(), rnd64(), 1'b0);

      // Reset during beat 3 of a dword store.
      @(negedge clk);
      start = 1'b1;
      size  = 2'd3;
      addr  = 64'h3000;
      wdata = 64'hDEAD_BEEF_CAFE_F00D;
      mem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_beat3_addr", mem_addr, 64'h3002);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_ctrl", {61'd0, busy, done, mem_wr_en}, 64'd0);
      chk("rst_async_addr", mem_addr, 64'd0);
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy || done || mem_wr_en) bad++;
      end
      chk("post_reset_quiet", 64'(bad), 64'd0);
      do_txn(2'd0, 64'h3100, 64'h0000_0000_0000_0042, 0, 1'b0);

      // Randomized transfers against the reference model.
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom_range(0, 3));
         d  = rnd64();
         if ($urandom_range(0, 1) == 1 && sz != 2'd3) begin
            t = d << (64 - (8 << sz));
            d = $signed(t) >>> (64 - (8 << sz));
         end
         do_txn(sz, rnd64(), d, 2, ref_ovf(sz, d));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
